// File: rtl/data_memory_lsu_if.sv
// Request/response bundle between the memory stage and data_memory_lsu.
// master: the load/store issuer. slave: the data memory itself.
interface data_memory_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  read_enable;
  logic                  write_enable;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           write_data;
  logic [31:0]           read_data;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  busy;

  modport master (
    output read_enable, write_enable, funct3, addr, write_data,
    input  read_data, misaligned, out_of_range, busy
  );

  modport slave (
    input  read_enable, write_enable, funct3, addr, write_data,
    output read_data, misaligned, out_of_range, busy
  );
endinterface

// File: rtl/data_memory_lsu.sv
// Word-organised data memory with RISC-V byte/half/word load-store support.
// After reset a clear sequencer zeroes every word before requests are served
// (busy=1 meanwhile). Misaligned, illegal-funct3 and out-of-range requests
// are flagged and never modify memory.
// Optional build macro DMEM_REG_READ_EN: registers read_data so the load
// result appears one cycle after the request (read-before-write on a
// same-cycle store). Undefined: read_data is combinational.
module data_memory_lsu #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  data_memory_lsu_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]            state;
  logic [IDX_W-1:0]      clear_idx;
  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            lane;
  logic                  active;
  logic                  req;
  logic                  illegal;
  logic                  bad_align;
  logic                  beyond;
  logic                  load_ok;
  logic                  store_ok;
  logic [31:0]           word;
  logic [31:0]           shifted;
  logic [31:0]           load_val;
  logic [3:0]            byte_en;
  logic [31:0]           store_val;

  // Address decomposition relative to the window base; an address below the
  // base or past the last word is out of range.
  assign off      = bus.addr - BASE_ADDR;
  assign word_idx = off[IDX_W+1:2];
  assign lane     = off[1:0];
  assign beyond   = (bus.addr < BASE_ADDR) || ((off >> (IDX_W + 2)) != '0);

  // Requests only count once the clear is done and reset is released.
  assign active = rst_n && (state == READY);
  assign req    = active && (bus.read_enable || bus.write_enable);

  // Classify funct3: reserved encodings are illegal, halves need an even
  // lane and words need lane 0.
  always_comb begin
    illegal   = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                (bus.funct3 == 3'b111);
    bad_align = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   bad_align = lane[0];
      2'b10:   bad_align = (lane != 2'b00);
      default: bad_align = 1'b0;
    endcase
  end

  assign bus.misaligned   = req && (illegal || bad_align);
  assign bus.out_of_range = req && beyond;

  assign load_ok  = active && bus.read_enable  && !illegal && !bad_align && !beyond;
  assign store_ok = active && bus.write_enable && !illegal && !bad_align && !beyond;

  // Load path: select the addressed lane(s) and sign/zero extend.
  always_comb begin
    word     = mem[word_idx];
    shifted  = word >> {lane, 3'b000};
    load_val = '0;
    if (load_ok) begin
      case (bus.funct3)
        3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  load_val = {24'h0, shifted[7:0]};
        3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
        3'b101:  load_val = {16'h0, shifted[15:0]};
        3'b010:  load_val = word;
        default: load_val = '0;
      endcase
    end
  end

  // Store path: move the low store bytes up to the target lane and build
  // the matching byte enables.
  always_comb begin
    store_val = bus.write_data << {lane, 3'b000};
    byte_en   = 4'b0000;
    case (bus.funct3[1:0])
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << lane;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Clear sequencer: reset parks it at word 0, then it walks every word once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clear_idx <= '0;
    end else if (state == CLEAR) begin
      clear_idx <= clear_idx + IDX_W'(1);
      if (clear_idx == IDX_W'(DEPTH - 1)) begin
        state <= READY;
      end
    end
  end

  // Memory array: zero writes from the sequencer, otherwise lane-masked stores.
  always_ff @(posedge clk) begin
    if (rst_n && (state == CLEAR)) begin
      mem[clear_idx] <= '0;
    end else if (store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= store_val[8*b +: 8];
        end
      end
    end
  end

  assign bus.busy = (state == CLEAR);

`ifdef DMEM_REG_READ_EN
  logic [31:0] read_q;

  // Registered load result; captured from pre-store contents so a same-cycle
  // store to the same word returns the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_q <= '0;
    end else if (state == CLEAR) begin
      read_q <= '0;
    end else begin
      read_q <= load_val;
    end
  end

  assign bus.read_data = read_q;
`else
  assign bus.read_data = load_val;
`endif

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: a byte-array reference model predicts
// each response, expectations are queued by cycle, and a negedge monitor
// compares them against the DUT.
module tb_data_memory_lsu;

  localparam int          ADDR_WIDTH = 32;
  localparam int          DEPTH      = 1024;
  localparam logic [31:0] BASE_ADDR  = 32'h0;
`ifdef DMEM_REG_READ_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  model [4*DEPTH];

  data_memory_lsu_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  data_memory_lsu #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used to schedule expectations.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] addr,
                              input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s addr=0x%08h got=0x%08h expected=0x%08h", name, addr, actual, expected);
    end
  endtask

  // Monitor: pop every expectation due this cycle and compare.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc != cyc) begin
        check_output("schedule", mon_e.addr, cyc, mon_e.cyc);
      end else begin
        case (mon_e.kind)
          0:       check_output("read_data", mon_e.addr, bus.read_data, mon_e.val);
          1:       check_output("misaligned", mon_e.addr, {31'h0, bus.misaligned}, mon_e.val);
          default: check_output("out_of_range", mon_e.addr, {31'h0, bus.out_of_range}, mon_e.val);
        endcase
      end
    end
  end

  function automatic int access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] off);
    case (f3)
      3'b000:  return {{24{model[off][7]}}, model[off]};
      3'b100:  return {24'h0, model[off]};
      3'b001:  return {{16{model[off+1][7]}}, model[off+1], model[off]};
      3'b101:  return {16'h0, model[off+1], model[off]};
      3'b010:  return {model[off+3], model[off+2], model[off+1], model[off]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 4*DEPTH; i++) model[i] = 8'h00;
  endtask

  task automatic push(input int c, input int kind, input logic [31:0] val, input logic [31:0] a);
    exp_t e;
    e.cyc = c; e.kind = kind; e.val = val; e.addr = a;
    sb.push_back(e);
  endtask

  // Drive one request cycle and queue the model's prediction for it.
  task automatic apply_stimulus(input logic re, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd);
    int          sz;
    logic        ill, mis, oor;
    logic [31:0] off, rd;
    @(posedge clk);
    #1;
    bus.read_enable  = re;
    bus.write_enable = we;
    bus.funct3       = f3;
    bus.addr         = a;
    bus.write_data   = wd;
    sz  = access_size(f3);
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    off = a - BASE_ADDR;
    mis = (re || we) && (ill || (sz != 0 && (off % sz) != 0));
    oor = (re || we) && ((a < BASE_ADDR) || (off >= 4*DEPTH));
    rd  = (re && !mis && !oor) ? model_load(f3, off) : 32'h0;
    push(cyc, 1, {31'h0, mis}, a);
    push(cyc, 2, {31'h0, oor}, a);
    push(cyc + LAT, 0, rd, a);
    if (we && !mis && !oor) begin
      for (int k = 0; k < sz; k++) model[off + k] = wd[8*k +: 8];
    end
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  // Let pending expectations come due; anything left over is a failure.
  task automatic drain();
    repeat (2) apply_idle();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      check_output("drain", 32'h0, sb.size(), 0);
      sb.delete();
    end
  endtask

  // Count busy cycles from the release negedge; optionally inject a store
  // during the clear or re-assert reset part-way through it.
  task automatic run_clear(input int inject_at, input int reset_at, output int n);
    int guard = 0;
    bit did_reset = 0;
    n = 0;
    while (bus.busy && guard < 5000) begin
      n++;
      guard++;
      if (n == inject_at) begin
        bus.read_enable  = 1'b1;
        bus.write_enable = 1'b1;
        bus.funct3       = 3'b010;
        bus.addr         = 32'h0;
        bus.write_data   = 32'h12345678;
        #1;
        check_output("busy_misaligned", 32'h0, {31'h0, bus.misaligned}, 32'h0);
        check_output("busy_out_of_range", 32'h0, {31'h0, bus.out_of_range}, 32'h0);
        check_output("busy_read_data", 32'h0, bus.read_data, 32'h0);
      end
      if (n == inject_at + 1) begin
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
      end
      if (n == reset_at && !did_reset) begin
        did_reset = 1;
        rst_n = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check_output("busy_in_reset", 32'h0, {31'h0, bus.busy}, 32'h1);
        end
        rst_n = 1'b1;
        n = 0;
      end else begin
        @(negedge clk);
      end
    end
    if (guard >= 5000) check_output("clear_timeout", 32'h0, guard, 0);
  endtask

  initial begin
    int n;
    logic [2:0] f3_pool [6];
    f3_pool[0] = 3'b000; f3_pool[1] = 3'b001; f3_pool[2] = 3'b010;
    f3_pool[3] = 3'b100; f3_pool[4] = 3'b101; f3_pool[5] = 3'b011;

    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    bus.funct3       = 3'b000;
    bus.addr         = 32'h0;
    bus.write_data   = 32'h0;
    model_zero();

    // Power-up clear with a store injected during clear cycle 5.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_clear(5, 0, n);
    check_output("clear_cycles", 32'h0, n, 1024);
    check_output("busy_after_clear", 32'h0, {31'h0, bus.busy}, 32'h0);

    // Every word reads back zero (word 0 also proves the dropped store).
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 1'b0, 3'b010, 32'(4*i), 32'h0);

    // Byte/half stores into one word and sign/zero-extended loads.
    apply_stimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344);
    apply_stimulus(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA);
    apply_stimulus(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF);
    apply_stimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'b100, 32'h11, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);

    // Faults: misaligned store, misaligned half load, illegal funct3, range.
    apply_stimulus(1'b0, 1'b1, 3'b010, 32'h20, 32'h01020304);
    apply_stimulus(1'b0, 1'b1, 3'b010, 32'h22, 32'hDEADBEEF);
    apply_stimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'b001, 32'h13, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'b111, 32'h20, 32'hFFFFFFFF);
    apply_stimulus(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'b010, 32'h1004, 32'h55555555);
    apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0FFC, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);

    // Simultaneous load and store: old data now, new data afterwards.
    apply_stimulus(1'b1, 1'b1, 3'b010, 32'h40, 32'h00000005);
    apply_stimulus(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);

    // Randomised traffic over the window plus a margin beyond it.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? 32'(4*DEPTH + $urandom_range(0, 63))
                                       : 32'($urandom_range(0, 255));
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     f3_pool[$urandom_range(0, 5)], a, $urandom);
    end
    drain();

    // Reset mid-clear: preload, reset, interrupt the clear at cycle 500.
    apply_stimulus(1'b0, 1'b1, 3'b010, 32'h100, 32'hCAFEF00D);
    apply_stimulus(1'b0, 1'b1, 3'b010, 32'h0, 32'h12345678);
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_zero();
    run_clear(0, 500, n);
    check_output("clear_cycles_after_restart", 32'h0, n, 1024);
    apply_stimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
